// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter/rotator with valid/ready flow control.
// The LOG2W mux levels are spread across STAGES register stages. Each stage
// register carries partial data, partial sticky, control bits and a valid flag.
module barrel_shifter_pipe #(
  parameter int unsigned W      = 64,
  parameter int unsigned LOG2W  = 6,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             dir,
  input  logic             op,
  input  logic             shift_t,
  input  logic [LOG2W-1:0] sel,
  input  logic [W-1:0]     in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out,
  output logic             sticky
);

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] sticky_q, sticky_d;
  logic [W-1:0]      data_q   [STAGES];
  logic [W-1:0]      data_d   [STAGES];
  logic              dir_q    [STAGES];
  logic              dir_d    [STAGES];
  logic              op_q     [STAGES];
  logic              op_d     [STAGES];
  logic              sht_q    [STAGES];
  logic              sht_d    [STAGES];
  logic [LOG2W-1:0]  sel_q    [STAGES];
  logic [LOG2W-1:0]  sel_d    [STAGES];
  logic [STAGES-1:0] ld;

  // Load enables: a stage loads when empty or when the stage after it moves.
  // Walked from the output back so empty stages let upstream words advance.
  always_comb begin : ready_chain
    logic r;
    r  = out_ready;
    ld = '0;
    for (int unsigned j = 0; j < STAGES; j++) begin
      r               = !v_q[STAGES-1-j] | r;
      ld[STAGES-1-j]  = r;
    end
  end

  assign in_ready = ld[0];

  // Per-stage next state: pick the stage input, apply the mux levels owned by
  // this stage, and load only on a handshake into the stage.
  always_comb begin : stage_logic
    logic             vi;
    logic [W-1:0]     d;
    logic             st;
    logic             dri;
    logic             opi;
    logic             shi;
    logic [LOG2W-1:0] sli;
    logic [W-1:0]     lo_mask;
    logic [W-1:0]     hi_mask;
    int unsigned      amt;
    vi      = 1'b0;
    d       = '0;
    st      = 1'b0;
    dri     = 1'b0;
    opi     = 1'b0;
    shi     = 1'b0;
    sli     = '0;
    lo_mask = '0;
    hi_mask = '0;
    amt     = 0;
    v_d      = v_q;
    sticky_d = sticky_q;
    for (int unsigned k = 0; k < STAGES; k++) begin
      data_d[k] = data_q[k];
      dir_d[k]  = dir_q[k];
      op_d[k]   = op_q[k];
      sht_d[k]  = sht_q[k];
      sel_d[k]  = sel_q[k];
      if (k == 0) begin
        vi  = in_valid;
        d   = in;
        st  = 1'b0;
        dri = dir;
        opi = op;
        shi = shift_t;
        sli = sel;
      end else begin
        vi  = v_q[k-1];
        d   = data_q[k-1];
        st  = sticky_q[k-1];
        dri = dir_q[k-1];
        opi = op_q[k-1];
        shi = sht_q[k-1];
        sli = sel_q[k-1];
      end
      for (int unsigned i = 0; i < LOG2W; i++) begin
        if (((i * STAGES) / LOG2W) == k && sli[i]) begin
          amt     = 1 << i;
          lo_mask = ~({W{1'b1}} << amt);
          hi_mask = ~({W{1'b1}} >> amt);
          if (opi) begin
            d = dri ? ((d >> amt) | (d << (W - amt)))
                    : ((d << amt) | (d >> (W - amt)));
          end else if (dri) begin
            st = st | (|(d & lo_mask));
            d  = shi ? W'($signed(d) >>> amt) : (d >> amt);
          end else begin
            st = st | (|(d & hi_mask));
            d  = d << amt;
          end
        end
      end
      if (ld[k]) begin
        v_d[k] = vi;
        if (vi) begin
          data_d[k]   = d;
          sticky_d[k] = st;
          dir_d[k]    = dri;
          op_d[k]     = opi;
          sht_d[k]    = shi;
          sel_d[k]    = sli;
        end
      end
    end
  end

  // Stage registers; reset drops every word in flight.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      v_q      <= '0;
      sticky_q <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
        dir_q[k]  <= 1'b0;
        op_q[k]   <= 1'b0;
        sht_q[k]  <= 1'b0;
        sel_q[k]  <= '0;
      end
    end else begin
      v_q      <= v_d;
      sticky_q <= sticky_d;
      for (int unsigned k = 0; k < STAGES; k++) begin
        data_q[k] <= data_d[k];
        dir_q[k]  <= dir_d[k];
        op_q[k]   <= op_d[k];
        sht_q[k]  <= sht_d[k];
        sel_q[k]  <= sel_d[k];
      end
    end
  end

  // Output is the last stage register.
  always_comb begin
    out_valid = v_q[STAGES-1];
    out       = data_q[STAGES-1];
    sticky    = sticky_q[STAGES-1];
  end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench for barrel_shifter_pipe: directed cases, back-pressure,
// mid-stream reset, and a STAGES sweep against a behavioural reference model.
module tb_barrel_shifter_pipe;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        in_valid, in_ready, dir, op, shift_t;
  logic [5:0]  sel;
  logic [63:0] din, dout;
  logic        out_valid, out_ready, sticky;

  logic        sw_valid, sw_dir, sw_op, sw_sh;
  logic [5:0]  sw_sel;
  logic [63:0] sw_in;
  logic        sw_ordy;
  logic        sw_irdy [3];
  logic        sw_ov   [3];
  logic [63:0] sw_out  [3];
  logic        sw_st   [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit lat_chk = 1'b0;

  typedef struct {
    logic [63:0] o;
    logic        st;
    int          acc;
  } exp_t;
  exp_t q[$];

  logic [63:0] pend_o;
  logic        pend_st;

  bit          hv [2048];
  logic [63:0] ho [2048];
  logic        hs [2048];
  int          sst [3] = '{1, 3, 6};

  always #5 clk = ~clk;

  barrel_shifter_pipe #(.W(64), .LOG2W(6), .STAGES(S)) dut (
    .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dir(dir), .op(op), .shift_t(shift_t), .sel(sel), .in(din),
    .out_valid(out_valid), .out_ready(out_ready), .out(dout), .sticky(sticky)
  );

  barrel_shifter_pipe #(.W(64), .LOG2W(6), .STAGES(1)) dut_s1 (
    .clk(clk), .arst_n(arst_n), .in_valid(sw_valid), .in_ready(sw_irdy[0]),
    .dir(sw_dir), .op(sw_op), .shift_t(sw_sh), .sel(sw_sel), .in(sw_in),
    .out_valid(sw_ov[0]), .out_ready(sw_ordy), .out(sw_out[0]), .sticky(sw_st[0])
  );

  barrel_shifter_pipe #(.W(64), .LOG2W(6), .STAGES(3)) dut_s3 (
    .clk(clk), .arst_n(arst_n), .in_valid(sw_valid), .in_ready(sw_irdy[1]),
    .dir(sw_dir), .op(sw_op), .shift_t(sw_sh), .sel(sw_sel), .in(sw_in),
    .out_valid(sw_ov[1]), .out_ready(sw_ordy), .out(sw_out[1]), .sticky(sw_st[1])
  );

  barrel_shifter_pipe #(.W(64), .LOG2W(6), .STAGES(6)) dut_s6 (
    .clk(clk), .arst_n(arst_n), .in_valid(sw_valid), .in_ready(sw_irdy[2]),
    .dir(sw_dir), .op(sw_op), .shift_t(sw_sh), .sel(sw_sel), .in(sw_in),
    .out_valid(sw_ov[2]), .out_ready(sw_ordy), .out(sw_out[2]), .sticky(sw_st[2])
  );

  // Reference: shift through a 128-bit window, rotate bit by bit.
  function automatic void ref_model(input logic [63:0] d, input int s, input logic dr,
                                    input logic o, input logic sh,
                                    output logic [63:0] r, output logic st);
    logic [127:0] w;
    r  = '0;
    st = 1'b0;
    if (o) begin
      for (int j = 0; j < 64; j++)
        r[j] = dr ? d[(j + s) % 64] : d[(j - s + 64) % 64];
    end else if (!dr) begin
      w  = {64'd0, d} << s;
      r  = w[63:0];
      st = |w[127:64];
    end else begin
      w = {d, 64'd0};
      if (sh) w = $signed(w) >>> s;
      else    w = w >> s;
      r  = w[127:64];
      st = |w[63:0];
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(output bit acc);
    exp_t e;
    bit   exp_rdy;
    #1;
    exp_rdy = out_ready || (q.size() < S);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (out_valid === 1'b1 && out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        e = q.pop_front();
        chk("out", dout, e.o);
        chk("sticky", 64'(sticky), 64'(e.st));
        if (lat_chk) chk("latency", 64'(cyc - e.acc), 64'(S));
      end
    end
    acc = in_valid && exp_rdy;
    if (acc) q.push_back(exp_t'{pend_o, pend_st, cyc});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rnd_inputs();
    din     = {$urandom, $urandom};
    sel     = 6'($urandom_range(0, 63));
    dir     = 1'($urandom_range(0, 1));
    op      = 1'($urandom_range(0, 1));
    shift_t = 1'($urandom_range(0, 1));
    ref_model(din, int'(sel), dir, op, shift_t, pend_o, pend_st);
  endtask

  task automatic send_exp(input logic [63:0] d, input logic [5:0] s, input logic dr,
                          input logic o, input logic sh,
                          input logic [63:0] eo, input logic est);
    bit acc;
    int n;
    din = d; sel = s; dir = dr; op = o; shift_t = sh;
    pend_o = eo; pend_st = est;
    in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      step(acc);
      n++;
    end
    chk("send_accept", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      step(acc);
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    bit acc;
    int sent, t, words, c;
    arst_n = 1'b0;
    in_valid = 1'b0; dir = 1'b0; op = 1'b0; shift_t = 1'b0; sel = '0; din = '0;
    out_ready = 1'b1;
    sw_valid = 1'b0; sw_dir = 1'b0; sw_op = 1'b0; sw_sh = 1'b0; sw_sel = '0; sw_in = '0;
    sw_ordy = 1'b1;
    pend_o = '0; pend_st = 1'b0;

    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out", dout, 64'd0);
    chk("rst_sticky", 64'(sticky), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;

    // Directed values with latency checking.
    lat_chk = 1'b1;
    send_exp(64'h8000_0000_0000_00F1, 6'd4, 1'b1, 1'b0, 1'b1, 64'hF800_0000_0000_000F, 1'b1);
    drain();
    send_exp(64'h0123_4567_89AB_CDEF, 6'd8, 1'b0, 1'b1, 1'b0, 64'h2345_6789_ABCD_EF01, 1'b0);
    send_exp(64'h0123_4567_89AB_CDEF, 6'd8, 1'b1, 1'b1, 1'b1, 64'hEF01_2345_6789_ABCD, 1'b0);
    drain();
    send_exp(64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 1'b0, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b1);
    send_exp(64'hFFFF_FFFF_FFFF_FFFF, 6'd0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    drain();

    // Full-rate random stream.
    in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      rnd_inputs();
      step(acc);
    end
    drain();
    lat_chk = 1'b0;

    // Back-pressure: toggling ready, then held low, then released.
    sent = 0;
    t = 0;
    rnd_inputs();
    in_valid = 1'b1;
    while (sent < 10 && t < 60) begin
      out_ready = (t < 6) ? ((t % 2) == 0) : ((t < 11) ? 1'b0 : 1'b1);
      step(acc);
      if (acc) begin
        sent++;
        rnd_inputs();
      end
      t++;
    end
    drain();
    chk("bp_sent", 64'(sent), 64'd10);

    // Random valid and ready mix.
    rnd_inputs();
    for (int i = 0; i < 150; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      step(acc);
      if (acc) rnd_inputs();
    end
    drain();

    // Reset with words in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rnd_inputs();
      step(acc);
    end
    arst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out", dout, 64'd0);
    chk("midrst_sticky", 64'(sticky), 64'd0);
    q.delete();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("postrst_no_emit", 64'(out_valid), 64'd0);
      step(acc);
    end

    // STAGES sweep: identical stream into STAGES=1,3,6 with out_ready held 1.
    words = 0;
    c = 0;
    while (c < 2000) begin
      sw_valid = (words < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
      sw_in    = {$urandom, $urandom};
      sw_sel   = 6'($urandom_range(0, 63));
      sw_dir   = 1'($urandom_range(0, 1));
      sw_op    = 1'($urandom_range(0, 1));
      sw_sh    = 1'($urandom_range(0, 1));
      hv[c]    = sw_valid;
      ref_model(sw_in, int'(sw_sel), sw_dir, sw_op, sw_sh, ho[c], hs[c]);
      if (sw_valid) words++;
      #1;
      for (int m = 0; m < 3; m++) begin
        int  idx;
        bit  ev;
        idx = c - sst[m];
        ev  = (idx >= 0) && hv[idx];
        chk("sw_in_ready", 64'(sw_irdy[m]), 64'd1);
        chk("sw_out_valid", 64'(sw_ov[m]), 64'(ev));
        if (ev) begin
          chk("sw_out", sw_out[m], ho[idx]);
          chk("sw_sticky", 64'(sw_st[m]), 64'(hs[idx]));
        end
      end
      @(posedge clk);
      #1;
      c++;
      if (words >= 1000 && c > 0 && !hv[c-1] && (c >= 8) &&
          !hv[c-2] && !hv[c-3] && !hv[c-4] && !hv[c-5] && !hv[c-6] && !hv[c-7])
        break;
    end
    chk("sw_words", 64'(words), 64'd1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
